// File: rtl/flit_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flit_tx_arbiter_if
// Brief    : Flit source/sink handshake bundle shared by the TX arbiter and
//            its environment (packet builders on one side, link TX on the
//            other).
// Revision : 1.0 - initial release
// ============================================================================
interface flit_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = 64
) ();
    logic [N_REQ-1:0]        in_valid;
    logic [N_REQ*FLIT_W-1:0] in_flit;
    logic [N_REQ-1:0]        in_last;
    logic [N_REQ-1:0]        in_ready;
    logic                    out_valid;
    logic [FLIT_W-1:0]       out_flit;
    logic                    out_last;
    logic                    out_ready;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic                    err_overlong;

    // Arbiter side
    modport slave (
        input  in_valid, in_flit, in_last, out_ready,
        output in_ready, out_valid, out_flit, out_last, grant, busy, err_overlong
    );

    // Environment side (sources and transmitter)
    modport master (
        output in_valid, in_flit, in_last, out_ready,
        input  in_ready, out_valid, out_flit, out_last, grant, busy, err_overlong
    );
endinterface
`default_nettype wire

// File: rtl/flit_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flit_tx_arbiter
// Brief    : Round-robin, packet-locked arbiter sharing one outbound flit
//            channel among N_REQ sources. Grant is held head-to-tail; packets
//            longer than MAX_FLITS without a tail are cut off with an error
//            pulse.
// Revision : 1.0 - initial release
// ============================================================================
module flit_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FLIT_W    = 64,
    parameter int MAX_FLITS = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    flit_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    localparam logic [PTR_W-1:0] C_LAST_REQ  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(MAX_FLITS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_rr_ptr_nxt;
    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  w_owner_nxt;
    logic [PTR_W-1:0]  w_owner_inc;
    logic [PTR_W-1:0]  w_winner;
    logic [PTR_W-1:0]  w_idx;
    logic [CNT_W-1:0]  r_flit_cnt;
    logic [CNT_W-1:0]  w_flit_cnt_nxt;
    logic [FLIT_W-1:0] w_flit_arr [N_REQ];
    logic              w_xfer;
    logic              w_at_limit;

    // Split the flat flit bus into one word per requester for muxing
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_flit_arr[g] = bus.in_flit[g*FLIT_W +: FLIT_W];
        end
    endgenerate

    // Round-robin search: lowest offset from rr_ptr with a valid request wins
    always_comb begin
        w_winner = r_rr_ptr;
        w_idx    = r_rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + i) % N_REQ);
            if (bus.in_valid[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    assign w_owner_inc = (r_owner == C_LAST_REQ) ? '0 : r_owner + 1'b1;
    assign w_at_limit  = (r_flit_cnt == C_CNT_LIMIT);
    assign w_xfer      = bus.out_valid & bus.out_ready;

    // Datapath mux and handshake steering from the registered owner
    always_comb begin
        bus.grant     = '0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_flit  = '0;
        bus.out_last  = 1'b0;
        bus.in_ready  = '0;
        if (r_state == S_LOCKED) begin
            bus.grant[r_owner]    = 1'b1;
            bus.busy              = 1'b1;
            bus.out_valid         = bus.in_valid[r_owner];
            bus.out_flit          = w_flit_arr[r_owner];
            bus.out_last          = bus.in_last[r_owner];
            bus.in_ready[r_owner] = bus.out_ready;
        end
    end

    // Forced release: limit reached on a non-tail flit (a tail on that flit wins)
    assign bus.err_overlong = w_xfer & ~bus.out_last & w_at_limit;

    // Next-state: arbitrate in IDLE, count and release in LOCKED
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_flit_cnt_nxt = r_flit_cnt;
        case (r_state)
            S_IDLE: begin
                if (|bus.in_valid) begin
                    w_state_nxt    = S_LOCKED;
                    w_owner_nxt    = w_winner;
                    w_flit_cnt_nxt = '0;
                end
            end
            S_LOCKED: begin
                if (w_xfer) begin
                    w_flit_cnt_nxt = r_flit_cnt + 1'b1;
                    if (bus.out_last || w_at_limit) begin
                        w_state_nxt  = S_IDLE;
                        w_rr_ptr_nxt = w_owner_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_flit_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_flit_cnt <= w_flit_cnt_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_flit_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flit_tx_arbiter
// Brief    : Self-checking bench for flit_tx_arbiter: per-cycle vector table
//            plus scoreboarded multi-packet sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flit_tx_arbiter;
    localparam int N_REQ     = 4;
    localparam int FLIT_W    = 64;
    localparam int MAX_FLITS = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    flit_tx_arbiter_if #(.N_REQ(N_REQ), .FLIT_W(FLIT_W)) bus ();

    flit_tx_arbiter #(
        .N_REQ    (N_REQ),
        .FLIT_W   (FLIT_W),
        .MAX_FLITS(MAX_FLITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       rs;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       ordy;
        logic       chk;
        logic [3:0] e_grant;
        logic       e_busy;
        logic       e_ov;
        logic [3:0] e_ir;
    } vec_t;

    typedef struct {
        int          req;
        logic [63:0] flit;
        logic        last;
        int          cyc;
    } exp_t;

    vec_t        vecs [15];
    exp_t        exp_q [$];
    logic [64:0] src_q [N_REQ][$];
    int          err_cyc [$];
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic vec_t mkv(logic rs, logic [3:0] vld, logic [3:0] lst, logic ordy,
                                 logic chk, logic [3:0] g, logic b, logic ov, logic [3:0] ir);
        vec_t v;
        v.rs = rs; v.vld = vld; v.lst = lst; v.ordy = ordy; v.chk = chk;
        v.e_grant = g; v.e_busy = b; v.e_ov = ov; v.e_ir = ir;
        return v;
    endfunction

    function automatic logic [63:0] tbl_flit(int r);
        return {8'(8'hC0 + r), 56'h11_2233_4455_6677};
    endfunction

    function automatic logic [63:0] mk_flit(int r, int pid, int i);
        return {8'(r), 8'(pid), 48'(i)};
    endfunction

    task automatic add_pkt(int r, int pid, int n, bit tail);
        for (int i = 0; i < n; i++) begin
            src_q[r].push_back({(tail && (i == n - 1)), mk_flit(r, pid, i)});
        end
    endtask

    task automatic exp_flits(int r, int pid, int first, int n, int total, bit tail, int cyc0);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.req  = r;
            e.flit = mk_flit(r, pid, first + k);
            e.last = tail && (first + k == total - 1);
            e.cyc  = cyc0 + k;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_empty(string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d transfers missing, expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_grant_zero(string name);
        n_tests++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: grant=%b busy=%b, expected grant=0000 busy=0", name, bus.grant, bus.busy);
        end
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_flit   = '0;
        exp_q.delete();
        err_cyc.delete();
        for (int r = 0; r < N_REQ; r++) src_q[r].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock of source model + scoreboard compare of any transfer
    task automatic cycle();
        logic [64:0] head;
        logic [3:0]  one;
        exp_t        e;
        one = 4'b0001;
        for (int r = 0; r < N_REQ; r++) begin
            if (src_q[r].size() > 0) begin
                head = src_q[r][0];
                bus.in_valid[r]                  = 1'b1;
                bus.in_flit[r*FLIT_W +: FLIT_W]  = head[63:0];
                bus.in_last[r]                   = head[64];
            end else begin
                bus.in_valid[r]                  = 1'b0;
                bus.in_flit[r*FLIT_W +: FLIT_W]  = '0;
                bus.in_last[r]                   = 1'b0;
            end
        end
        #1;
        if (bus.err_overlong === 1'b1) err_cyc.push_back(cyc);
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra cyc=%0d: grant=%b flit=%h, expected no transfer",
                         cyc, bus.grant, bus.out_flit);
            end else begin
                e = exp_q.pop_front();
                if (bus.grant !== (one << e.req) || bus.out_flit !== e.flit ||
                    bus.out_last !== e.last || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL sb_xfer: got cyc=%0d grant=%b flit=%h last=%b, expected cyc=%0d grant=%b flit=%h last=%b",
                             cyc, bus.grant, bus.out_flit, bus.out_last,
                             e.cyc, one << e.req, e.flit, e.last);
                end
            end
            for (int r = 0; r < N_REQ; r++) begin
                if (bus.in_ready[r] && bus.in_valid[r]) void'(src_q[r].pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [63:0] e_flit;
        logic        e_last;

        // Vector table: reset, stall in flit 2 of req1, non-owner requests,
        // round-robin from rr_ptr, owner dropping valid mid-packet.
        vecs[0]  = mkv(1, 4'b1111, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b0000);
        vecs[1]  = mkv(1, 4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
        vecs[2]  = mkv(1, 4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
        vecs[3]  = mkv(0, 4'b0010, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
        vecs[4]  = mkv(0, 4'b0010, 4'b0000, 1, 1, 4'b0010, 1, 1, 4'b0010);
        vecs[5]  = mkv(0, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 4'b0000);
        vecs[6]  = mkv(0, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 4'b0000);
        vecs[7]  = mkv(0, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 4'b0000);
        vecs[8]  = mkv(0, 4'b1011, 4'b0010, 1, 1, 4'b0010, 1, 1, 4'b0010);
        vecs[9]  = mkv(0, 4'b1001, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
        vecs[10] = mkv(0, 4'b1001, 4'b1000, 1, 1, 4'b1000, 1, 1, 4'b1000);
        vecs[11] = mkv(0, 4'b0001, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);
        vecs[12] = mkv(0, 4'b0000, 4'b0000, 1, 1, 4'b0001, 1, 0, 4'b0001);
        vecs[13] = mkv(0, 4'b0001, 4'b0001, 1, 1, 4'b0001, 1, 1, 4'b0001);
        vecs[14] = mkv(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 4'b0000);

        for (int r = 0; r < N_REQ; r++) bus.in_flit[r*FLIT_W +: FLIT_W] = tbl_flit(r);

        for (int v = 0; v < 15; v++) begin
            rst           = vecs[v].rs;
            bus.in_valid  = vecs[v].vld;
            bus.in_last   = vecs[v].lst;
            bus.out_ready = vecs[v].ordy;
            #1;
            if (vecs[v].chk) begin
                e_flit = '0;
                e_last = 1'b0;
                for (int r = 0; r < N_REQ; r++) begin
                    if (vecs[v].e_grant[r]) begin
                        e_flit = tbl_flit(r);
                        e_last = vecs[v].lst[r];
                    end
                end
                n_tests++;
                if (bus.grant !== vecs[v].e_grant || bus.busy !== vecs[v].e_busy ||
                    bus.out_valid !== vecs[v].e_ov || bus.in_ready !== vecs[v].e_ir ||
                    bus.out_flit !== e_flit || bus.out_last !== e_last ||
                    bus.err_overlong !== 1'b0) begin
                    n_fail++;
                    $display("FAIL vec[%0d] got/exp: grant=%b/%b busy=%b/%b out_valid=%b/%b in_ready=%b/%b flit=%h/%h last=%b/%b err=%b/0",
                             v, bus.grant, vecs[v].e_grant, bus.busy, vecs[v].e_busy,
                             bus.out_valid, vecs[v].e_ov, bus.in_ready, vecs[v].e_ir,
                             bus.out_flit, e_flit, bus.out_last, e_last, bus.err_overlong);
                end
            end
            @(posedge clk);
            #1;
        end

        // Two 3-flit packets on req0 and req2, one bubble between them
        reset_dut();
        add_pkt(0, 1, 3, 1); exp_flits(0, 1, 0, 3, 3, 1, 1);
        add_pkt(2, 2, 3, 1); exp_flits(2, 2, 0, 3, 3, 1, 5);
        for (int k = 0; k < 10; k++) cycle();
        check_empty("two_pkts");

        // Back-to-back single-flit packets from all requesters
        reset_dut();
        add_pkt(0, 3, 1, 1); exp_flits(0, 3, 0, 1, 1, 1, 1);
        add_pkt(1, 3, 1, 1); exp_flits(1, 3, 0, 1, 1, 1, 3);
        add_pkt(2, 3, 1, 1); exp_flits(2, 3, 0, 1, 1, 1, 5);
        add_pkt(3, 3, 1, 1); exp_flits(3, 3, 0, 1, 1, 1, 7);
        add_pkt(0, 4, 1, 1); exp_flits(0, 4, 0, 1, 1, 1, 9);
        for (int k = 0; k < 12; k++) cycle();
        check_empty("rr_order");

        // Overlong packet on req3: cut at 16 flits, rr_ptr must return to 0
        reset_dut();
        add_pkt(3, 5, 20, 0); exp_flits(3, 5, 0, 16, 20, 0, 1);
        for (int k = 0; k < 26; k++) begin
            if (cyc == 17) begin
                check_grant_zero("overlong_idle");
                add_pkt(1, 6, 1, 1);
                exp_flits(1, 6, 0, 1, 1, 1, 18);
                exp_flits(3, 5, 16, 4, 20, 0, 20);
            end
            cycle();
        end
        check_empty("overlong");
        n_tests++;
        if (err_cyc.size() != 1 || err_cyc[0] != 16) begin
            n_fail++;
            $display("FAIL err_overlong: %0d pulses, first at cyc %0d, expected 1 pulse at cyc 16",
                     err_cyc.size(), (err_cyc.size() > 0) ? err_cyc[0] : -1);
        end

        // Reset in the middle of a req2 packet with every requester valid
        reset_dut();
        add_pkt(1, 7, 1, 1); exp_flits(1, 7, 0, 1, 1, 1, 1);
        for (int k = 0; k < 16; k++) begin
            if (cyc == 2) begin
                add_pkt(0, 8, 1, 1);
                add_pkt(2, 9, 5, 1);
                add_pkt(3, 10, 1, 1);
                exp_flits(2, 9, 0, 2, 5, 1, 3);
            end
            if (cyc == 5) begin
                rst           = 1'b1;
                bus.out_ready = 1'b0;
            end
            if (cyc == 6) begin
                rst           = 1'b0;
                bus.out_ready = 1'b1;
                check_grant_zero("midpkt_reset");
                exp_flits(0, 8, 0, 1, 1, 1, 7);
                exp_flits(2, 9, 2, 3, 5, 1, 9);
                exp_flits(3, 10, 0, 1, 1, 1, 13);
            end
            cycle();
        end
        check_empty("midpkt_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
